// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the bitmap scan controller: RGB565
//                field widths, default LCD timing values, the line/frame
//                phase encoding and the packed colour type.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // RGB565 field widths
    localparam int c_r_width   = 5;
    localparam int c_g_width   = 6;
    localparam int c_b_width   = 5;
    localparam int c_rgb_width = c_r_width + c_g_width + c_b_width;

    // Default horizontal timing, in pixel clocks
    localparam int c_def_h_active = 480;
    localparam int c_def_h_front  = 8;
    localparam int c_def_h_sync   = 4;
    localparam int c_def_h_back   = 43;

    // Default vertical timing, in lines
    localparam int c_def_v_active = 272;
    localparam int c_def_v_front  = 8;
    localparam int c_def_v_sync   = 4;
    localparam int c_def_v_back   = 12;

    // Phase of a line (horizontal) or of a frame (vertical)
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // RGB565 colour, red in the top bits
    typedef struct packed {
        logic [c_r_width-1:0] r;
        logic [c_g_width-1:0] g;
        logic [c_b_width-1:0] b;
    } rgb565_t;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_timing.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing
//  Description : Horizontal/vertical pixel counters, line and frame phase
//                FSMs and the stage-0 sync / data-enable decode.
//  Ports       : clk, rst        - pixel clock, synchronous active-high reset
//                o_frame_wrap    - last pixel of the last line (only when
//                                  BITMAP_BLINK_EN is defined)
//                o_hc_nxt/o_vc_nxt - counter values for the next cycle
//                o_act_nxt       - both phases ACTIVE in the next cycle
//                o_de            - data enable for the current counters
//                o_hsync_n/o_vsync_n - active-low syncs for current counters
//                o_sof           - current position is HC=0, VC=0
//  Config      : BITMAP_BLINK_EN adds the o_frame_wrap port.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FRONT  = c_def_h_front,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BACK   = c_def_h_back,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FRONT  = c_def_v_front,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BACK   = c_def_v_back,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BITMAP_BLINK_EN
    output logic            o_frame_wrap,
`endif
    output logic [HC_W-1:0] o_hc_nxt,
    output logic [VC_W-1:0] o_vc_nxt,
    output logic            o_act_nxt,
    output logic            o_de,
    output logic            o_hsync_n,
    output logic            o_vsync_n,
    output logic            o_sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Last count of each phase; the FSM moves on when the counter sits here
    localparam logic [HC_W-1:0] c_h_act_end = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0] c_h_fp_end  = HC_W'(H_ACTIVE + H_FRONT - 1);
    localparam logic [HC_W-1:0] c_h_sy_end  = HC_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [HC_W-1:0] c_h_last    = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] c_v_act_end = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] c_v_fp_end  = VC_W'(V_ACTIVE + V_FRONT - 1);
    localparam logic [VC_W-1:0] c_v_sy_end  = VC_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [VC_W-1:0] c_v_last    = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    phase_e          h_ph_q, h_ph_d;
    phase_e          v_ph_q, v_ph_d;
    logic            w_line_end;
    logic            w_frame_end;

    always_comb begin
        w_line_end  = (hc_q == c_h_last);
        w_frame_end = w_line_end && (vc_q == c_v_last);

        hc_d = w_line_end ? '0 : hc_q + HC_W'(1);
        vc_d = vc_q;
        if (w_line_end) begin
            vc_d = (vc_q == c_v_last) ? '0 : vc_q + VC_W'(1);
        end

        h_ph_d = h_ph_q;
        case (h_ph_q)
            PH_ACTIVE: if (hc_q == c_h_act_end) h_ph_d = PH_FRONT;
            PH_FRONT:  if (hc_q == c_h_fp_end)  h_ph_d = PH_SYNC;
            PH_SYNC:   if (hc_q == c_h_sy_end)  h_ph_d = PH_BACK;
            PH_BACK:   if (w_line_end)          h_ph_d = PH_ACTIVE;
            default:                            h_ph_d = PH_ACTIVE;
        endcase

        // The frame FSM only moves at the end of a line
        v_ph_d = v_ph_q;
        if (w_line_end) begin
            case (v_ph_q)
                PH_ACTIVE: if (vc_q == c_v_act_end) v_ph_d = PH_FRONT;
                PH_FRONT:  if (vc_q == c_v_fp_end)  v_ph_d = PH_SYNC;
                PH_SYNC:   if (vc_q == c_v_sy_end)  v_ph_d = PH_BACK;
                PH_BACK:   if (vc_q == c_v_last)    v_ph_d = PH_ACTIVE;
                default:                            v_ph_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            h_ph_q <= PH_ACTIVE;
            v_ph_q <= PH_ACTIVE;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            h_ph_q <= h_ph_d;
            v_ph_q <= v_ph_d;
        end
    end

    // Next-cycle view lets the top register the ROM address so that it
    // lines up with the counters and ROM data lines up with stage 1.
    assign o_hc_nxt  = hc_d;
    assign o_vc_nxt  = vc_d;
    assign o_act_nxt = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);

    assign o_de      = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
    assign o_hsync_n = (h_ph_q != PH_SYNC);
    assign o_vsync_n = (v_ph_q != PH_SYNC);
    assign o_sof     = (hc_q == '0) && (vc_q == '0);

`ifdef BITMAP_BLINK_EN
    assign o_frame_wrap = w_frame_end;
`endif

endmodule : lcd_timing
`default_nettype wire

// File: rtl/bitmap_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bitmap_scan_ctrl
//  Description : Scans a monochrome bitmap ROM onto an RGB565 parallel LCD.
//                Stage 0 is the counter position; stage 1 (one cycle later,
//                aligned with the ROM data) drives all LCD_* outputs.
//  Ports       : CLK, RESET            - pixel clock, synchronous active-high
//                PIXEL                 - ROM bit for the previous address
//                FG_COLOR, BG_COLOR    - RGB565 colours, latched per frame
//                BMP_X, BMP_Y          - registered ROM address
//                LCD_DE/HSYNC/VSYNC    - data enable, active-low syncs
//                LCD_R/G/B             - pixel colour
//                FRAME_START           - one-cycle pulse at the first pixel
//  Config      : BITMAP_BLINK_EN - 6-bit frame counter; FG/BG swap inside
//                the bitmap window while its bit 5 is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitmap_scan_ctrl
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE   = c_def_h_active,
    parameter int H_FRONT    = c_def_h_front,
    parameter int H_SYNC     = c_def_h_sync,
    parameter int H_BACK     = c_def_h_back,
    parameter int V_ACTIVE   = c_def_v_active,
    parameter int V_FRONT    = c_def_v_front,
    parameter int V_SYNC     = c_def_v_sync,
    parameter int V_BACK     = c_def_v_back,
    parameter int BMP_W      = 256,
    parameter int BMP_H      = 128,
    parameter int BMP_X0     = 112,
    parameter int BMP_Y0     = 72,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PIXEL,
    input  logic [c_rgb_width-1:0] FG_COLOR,
    input  logic [c_rgb_width-1:0] BG_COLOR,
    output logic [ADDR_WIDTH-1:0]  BMP_X,
    output logic [ADDR_WIDTH-1:0]  BMP_Y,
    output logic                   LCD_DE,
    output logic                   LCD_HSYNC,
    output logic                   LCD_VSYNC,
    output logic [c_r_width-1:0]   LCD_R,
    output logic [c_g_width-1:0]   LCD_G,
    output logic [c_b_width-1:0]   LCD_B,
    output logic                   FRAME_START
);

    localparam int HC_W = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam int VC_W = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);

    // Window bounds in counter width (half-open ranges)
    localparam logic [HC_W-1:0] c_x_lo = HC_W'(BMP_X0);
    localparam logic [HC_W-1:0] c_x_hi = HC_W'(BMP_X0 + BMP_W);
    localparam logic [VC_W-1:0] c_y_lo = VC_W'(BMP_Y0);
    localparam logic [VC_W-1:0] c_y_hi = VC_W'(BMP_Y0 + BMP_H);

    logic [HC_W-1:0] w_hc_nxt;
    logic [VC_W-1:0] w_vc_nxt;
    logic            w_act_nxt;
    logic            w_de;
    logic            w_hsync_n;
    logic            w_vsync_n;
    logic            w_sof;
    logic            w_win_nxt;
    logic            w_swap;
    rgb565_t         w_color;

    // Address stage (aligned with the counters)
    logic [ADDR_WIDTH-1:0] bmp_x_q, bmp_x_d;
    logic [ADDR_WIDTH-1:0] bmp_y_q, bmp_y_d;
    logic                  win0_q, win0_d;

    // Output stage (one cycle behind the counters)
    logic                  de_q, de_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  fs_q, fs_d;
    logic                  win1_q, win1_d;

    // Per-frame colour latches
    rgb565_t               fg_q, fg_d;
    rgb565_t               bg_q, bg_d;

`ifdef BITMAP_BLINK_EN
    logic                  w_frame_wrap;
    logic [5:0]            blink_q, blink_d;
`endif

    lcd_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .HC_W     (HC_W),
        .VC_W     (VC_W)
    ) u_timing (
        .clk          (CLK),
        .rst          (RESET),
`ifdef BITMAP_BLINK_EN
        .o_frame_wrap (w_frame_wrap),
`endif
        .o_hc_nxt     (w_hc_nxt),
        .o_vc_nxt     (w_vc_nxt),
        .o_act_nxt    (w_act_nxt),
        .o_de         (w_de),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n),
        .o_sof        (w_sof)
    );

    always_comb begin
        // Address is computed from the next counter values so the registered
        // BMP_X/BMP_Y match the current HC/VC and the ROM answer arrives in
        // step with the stage-1 outputs.
        w_win_nxt = w_act_nxt
                 && (w_hc_nxt >= c_x_lo) && (w_hc_nxt < c_x_hi)
                 && (w_vc_nxt >= c_y_lo) && (w_vc_nxt < c_y_hi);
        bmp_x_d = w_win_nxt ? ADDR_WIDTH'(w_hc_nxt - c_x_lo) : '0;
        bmp_y_d = w_win_nxt ? ADDR_WIDTH'(w_vc_nxt - c_y_lo) : '0;
        win0_d  = w_win_nxt;

        de_d    = w_de;
        hsync_d = w_hsync_n;
        vsync_d = w_vsync_n;
        fs_d    = w_sof;
        win1_d  = win0_q;

        // Colours are captured on the first pixel of a frame, so the output
        // of that pixel already uses the new values.
        fg_d = w_sof ? rgb565_t'(FG_COLOR) : fg_q;
        bg_d = w_sof ? rgb565_t'(BG_COLOR) : bg_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bmp_x_q <= '0;
            bmp_y_q <= '0;
            win0_q  <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            win1_q  <= 1'b0;
            fg_q    <= '0;
            bg_q    <= '0;
        end else begin
            bmp_x_q <= bmp_x_d;
            bmp_y_q <= bmp_y_d;
            win0_q  <= win0_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            win1_q  <= win1_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
        end
    end

`ifdef BITMAP_BLINK_EN
    always_comb begin
        blink_d = w_frame_wrap ? blink_q + 6'd1 : blink_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    // Colour select: PIXEL is already stage-1 aligned, so it joins the
    // registered flags combinationally rather than adding a cycle.
    always_comb begin
`ifdef BITMAP_BLINK_EN
        w_swap = blink_q[5];
`else
        w_swap = 1'b0;
`endif
        w_color = '0;
        if (de_q) begin
            w_color = bg_q;
            if (win1_q) begin
                w_color = (PIXEL ^ w_swap) ? fg_q : bg_q;
            end
        end
    end

    assign BMP_X       = bmp_x_q;
    assign BMP_Y       = bmp_y_q;
    assign LCD_DE      = de_q;
    assign LCD_HSYNC   = hsync_q;
    assign LCD_VSYNC   = vsync_q;
    assign LCD_R       = w_color.r;
    assign LCD_G       = w_color.g;
    assign LCD_B       = w_color.b;
    assign FRAME_START = fs_q;

endmodule : bitmap_scan_ctrl
`default_nettype wire
